aes_block_packer: RTL and testbench

Byte-stream front end for the AES-128 encrypt core. Accepts a message one byte at a time over a valid/ready handshake and packs bytes into 128-bit blocks, first byte in bits [127:120]. Applies PKCS#7 padding to the final block when enabled. Presents each finished block on a valid/ready output that feeds the encryptor's 128-bit data input; a block is held stable until it is accepted.

---
 rtl/aes_block_packer_if.sv | 22 ++
 rtl/aes_block_packer.sv | 139 +++++++++++++
 tb/tb_aes_block_packer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_packer_if.sv
// Byte-in / block-out handshake bundle between a message source, the packer
// and the AES-128 encryptor data input.
interface aes_block_packer_if;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;

  modport master (
    output in_byte, in_valid, in_last, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_last
  );

  modport slave (
    input  in_byte, in_valid, in_last, blk_ready,
    output in_ready, blk_data, blk_valid, blk_last
  );
endinterface

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit AES blocks (first byte in [127:120]),
// with optional PKCS#7 padding of the final block.
module aes_block_packer #(
  parameter bit PAD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  aes_block_packer_if.slave bus
);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    PADBLK = 1'b1
  } state_t;

  state_t       state_r, state_nxt_s;
  logic [119:0] asm_r, asm_nxt_s;
  logic [3:0]   cnt_r, cnt_nxt_s;
  logic [127:0] data_r, data_nxt_s;
  logic         valid_r, valid_nxt_s;
  logic         last_r, last_nxt_s;
  logic         slot_free_s;
  logic         in_ready_s;
  logic         in_xfer_s;
  logic [127:0] word_s;

  // Bytes below cnt come from the assembly buffer, byte cnt is the incoming
  // byte, everything above is the pad value (or zero when padding is off).
  function automatic logic [127:0] build_word(
    input logic [119:0] asm_v,
    input logic [3:0]   cnt_v,
    input logic [7:0]   byte_v
  );
    logic [127:0] src_v;
    logic [127:0] res_v;
    logic [7:0]   pad_v;
    src_v = {asm_v, 8'h00};
    pad_v = PAD_EN ? {4'h0, 4'hf - cnt_v} : 8'h00;
    res_v = 128'd0;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) < cnt_v) begin
        res_v[127-8*i -: 8] = src_v[127-8*i -: 8];
      end else if (4'(i) == cnt_v) begin
        res_v[127-8*i -: 8] = byte_v;
      end else begin
        res_v[127-8*i -: 8] = pad_v;
      end
    end
    return res_v;
  endfunction

  assign slot_free_s = !valid_r || bus.blk_ready;
  assign in_ready_s  = (state_r == FILL) ? slot_free_s : 1'b0;
  assign in_xfer_s   = bus.in_valid && in_ready_s;
  assign word_s      = build_word(asm_r, cnt_r, bus.in_byte);

  assign bus.in_ready  = in_ready_s;
  assign bus.blk_data  = data_r;
  assign bus.blk_valid = valid_r;
  assign bus.blk_last  = last_r;

  // Next-state logic: byte assembly, block completion and the trailing pad block.
  always_comb begin
    state_nxt_s = state_r;
    asm_nxt_s   = asm_r;
    cnt_nxt_s   = cnt_r;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    last_nxt_s  = last_r;

    if (valid_r && bus.blk_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end

    case (state_r)
      FILL: begin
        if (in_xfer_s) begin
          if ((cnt_r == 4'd15) || bus.in_last) begin
            data_nxt_s  = word_s;
            valid_nxt_s = 1'b1;
            last_nxt_s  = bus.in_last && ((cnt_r != 4'd15) || !PAD_EN);
            cnt_nxt_s   = 4'd0;
            if (bus.in_last && (cnt_r == 4'd15) && PAD_EN) begin
              state_nxt_s = PADBLK;
            end else begin
              state_nxt_s = FILL;
            end
          end else begin
            for (int i = 0; i < 15; i++) begin
              if (4'(i) == cnt_r) begin
                asm_nxt_s[119-8*i -: 8] = bus.in_byte;
              end else begin
                asm_nxt_s[119-8*i -: 8] = asm_r[119-8*i -: 8];
              end
            end
            cnt_nxt_s = cnt_r + 4'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      PADBLK: begin
        if (slot_free_s) begin
          data_nxt_s  = {16{8'h10}};
          valid_nxt_s = 1'b1;
          last_nxt_s  = 1'b1;
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = PADBLK;
        end
      end
      default: begin
        state_nxt_s = FILL;
      end
    endcase
  end

  // State, assembly buffer and output block registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
      asm_r   <= 120'd0;
      cnt_r   <= 4'd0;
      data_r  <= 128'd0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      asm_r   <= asm_nxt_s;
      cnt_r   <= cnt_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: one padded and one zero-fill instance,
// selected per scenario, with expected blocks queued as messages are sent.
module tb_aes_block_packer;

  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } exp_t;

  logic clk;
  logic rst;
  logic sel;
  logic [7:0] in_byte_d;
  logic in_valid_d;
  logic in_last_d;
  logic blk_ready_d;

  int vectors;
  int miscompares;
  int cyc;
  int ready_low_cnt;

  exp_t exp_q[$];
  int   xfer_cyc[$];
  logic [7:0] msg_q[$];

  aes_block_packer_if ifp ();
  aes_block_packer_if ifn ();

  aes_block_packer #(.PAD_EN(1'b1)) u_pad (.clk(clk), .rst(rst), .bus(ifp.slave));
  aes_block_packer #(.PAD_EN(1'b0)) u_nopad (.clk(clk), .rst(rst), .bus(ifn.slave));

  assign ifp.in_byte   = in_byte_d;
  assign ifp.in_valid  = sel & in_valid_d;
  assign ifp.in_last   = in_last_d;
  assign ifp.blk_ready = sel ? blk_ready_d : 1'b1;
  assign ifn.in_byte   = in_byte_d;
  assign ifn.in_valid  = !sel & in_valid_d;
  assign ifn.in_last   = in_last_d;
  assign ifn.blk_ready = sel ? 1'b1 : blk_ready_d;

  wire         obs_in_ready = sel ? ifp.in_ready  : ifn.in_ready;
  wire [127:0] obs_data     = sel ? ifp.blk_data  : ifn.blk_data;
  wire         obs_valid    = sel ? ifp.blk_valid : ifn.blk_valid;
  wire         obs_last     = sel ? ifp.blk_last  : ifn.blk_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted block is checked against the queued model output.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!obs_in_ready) ready_low_cnt = ready_low_cnt + 1;
      if (obs_valid && blk_ready_d) begin
        xfer_cyc.push_back(cyc);
        vectors = vectors + 1;
        if (exp_q.size() == 0) begin
          miscompares = miscompares + 1;
          $display("FAIL unexpected_block: got data=%h last=%b, required no block", obs_data, obs_last);
        end else begin
          e = exp_q.pop_front();
          if (obs_data !== e.d || obs_last !== e.l) begin
            miscompares = miscompares + 1;
            $display("FAIL block: got data=%h last=%b, required data=%h last=%b",
                     obs_data, obs_last, e.d, e.l);
          end
        end
      end
    end
  end

  // Independent PKCS#7 / zero-fill model of the message in msg_q.
  task automatic push_expected(input bit pad);
    int n;
    int nblk;
    int r;
    exp_t e;
    n = msg_q.size();
    nblk = (n + 15) / 16;
    for (int b = 0; b < nblk; b++) begin
      r = n - 16 * b;
      if (r > 16) r = 16;
      e.d = 128'd0;
      for (int k = 0; k < 16; k++) begin
        if (k < r) e.d[127-8*k -: 8] = msg_q[16*b + k];
        else       e.d[127-8*k -: 8] = pad ? 8'(16 - r) : 8'h00;
      end
      e.l = (b == nblk - 1) && ((r < 16) || !pad);
      exp_q.push_back(e);
    end
    if (pad && (n % 16 == 0)) begin
      e.d = {16{8'h10}};
      e.l = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_bytes(input bit with_last);
    int tmo;
    for (int i = 0; i < msg_q.size(); i++) begin
      in_byte_d  = msg_q[i];
      in_valid_d = 1'b1;
      in_last_d  = with_last && (i == msg_q.size() - 1);
      tmo = 0;
      @(negedge clk);
      while (!obs_in_ready && tmo < 200) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 200) begin
        vectors = vectors + 1;
        miscompares = miscompares + 1;
        $display("FAIL in_ready_timeout: byte %0d not accepted, required acceptance within 200 cycles", i);
      end
      @(posedge clk);
      #1;
    end
    in_valid_d = 1'b0;
    in_last_d  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL %s_drain: got %0d blocks outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors = vectors + 4;
    if (obs_in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b, required 1", obs_in_ready); end
    if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL rst_blk_valid: got %b, required 0", obs_valid); end
    if (obs_last !== 1'b0) begin miscompares++; $display("FAIL rst_blk_last: got %b, required 0", obs_last); end
    if (obs_data !== 128'd0) begin miscompares++; $display("FAIL rst_blk_data: got %h, required 0", obs_data); end
  endtask

  task automatic test_fips();
    sel = 1'b1;
    blk_ready_d = 1'b1;
    msg_q.delete();
    for (int i = 0; i < 16; i++) msg_q.push_back(8'(i * 17));
    push_expected(1'b1);
    ready_low_cnt = 0;
    drive_bytes(1'b1);
    wait_drain("fips");
    vectors = vectors + 1;
    if (ready_low_cnt != 1) begin
      miscompares++;
      $display("FAIL fips_in_ready_low: got %0d cycles, required 1", ready_low_cnt);
    end
  endtask

  task automatic test_partial(input bit pad);
    sel = pad;
    blk_ready_d = 1'b1;
    msg_q = '{8'haa, 8'hbb, 8'hcc};
    push_expected(pad);
    drive_bytes(1'b1);
    wait_drain(pad ? "partial_pad" : "partial_zero");
  endtask

  task automatic test_full_nopad();
    sel = 1'b0;
    blk_ready_d = 1'b1;
    msg_q.delete();
    for (int i = 0; i < 16; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    push_expected(1'b0);
    xfer_cyc.delete();
    drive_bytes(1'b1);
    wait_drain("full_nopad");
    vectors = vectors + 1;
    if (xfer_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL full_nopad_count: got %0d blocks, required 1", xfer_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    int t;
    sel = 1'b0;
    blk_ready_d = 1'b0;
    msg_q.delete();
    for (int i = 0; i < 32; i++) msg_q.push_back(8'(i));
    push_expected(1'b0);
    fork
      drive_bytes(1'b1);
      begin
        t = 0;
        @(negedge clk);
        while (!obs_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        vectors = vectors + 1;
        if (!obs_valid) begin
          miscompares++;
          $display("FAIL bp_first_block: got blk_valid=0, required 1 within 100 cycles");
        end
        for (int i = 0; i < 20; i++) begin
          if (i > 0) @(negedge clk);
          vectors = vectors + 2;
          if (obs_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_in_ready: stall cycle %0d got %b, required 0", i, obs_in_ready);
          end
          if (obs_data !== 128'h000102030405060708090a0b0c0d0e0f || obs_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold: stall cycle %0d got valid=%b data=%h, required valid=1 data=000102030405060708090a0b0c0d0e0f",
                     i, obs_valid, obs_data);
          end
        end
        @(posedge clk);
        #1;
        blk_ready_d = 1'b1;
      end
    join
    wait_drain("backpressure");
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    blk_ready_d = 1'b1;
    msg_q.delete();
    for (int i = 0; i < 48; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    push_expected(1'b1);
    xfer_cyc.delete();
    drive_bytes(1'b1);
    wait_drain("b2b");
    vectors = vectors + 1;
    if (xfer_cyc.size() != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d blocks, required 4", xfer_cyc.size());
    end else begin
      vectors = vectors + 2;
      if (xfer_cyc[1] - xfer_cyc[0] != 16 || xfer_cyc[2] - xfer_cyc[1] != 16) begin
        miscompares++;
        $display("FAIL b2b_spacing: got %0d,%0d cycles, required 16,16",
                 xfer_cyc[1] - xfer_cyc[0], xfer_cyc[2] - xfer_cyc[1]);
      end
      if (xfer_cyc[3] - xfer_cyc[2] != 1) begin
        miscompares++;
        $display("FAIL b2b_pad_spacing: got %0d cycles, required 1", xfer_cyc[3] - xfer_cyc[2]);
      end
    end
  endtask

  task automatic test_mid_reset();
    sel = 1'b1;
    blk_ready_d = 1'b1;
    msg_q.delete();
    for (int i = 0; i < 7; i++) msg_q.push_back(8'(8'h30 + i));
    drive_bytes(1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors = vectors + 1;
      if (obs_in_ready !== 1'b1 || obs_valid !== 1'b0 || obs_last !== 1'b0 || obs_data !== 128'd0) begin
        miscompares++;
        $display("FAIL midrst_outputs: got ready=%b valid=%b last=%b data=%h, required 1 0 0 0",
                 obs_in_ready, obs_valid, obs_last, obs_data);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    msg_q = '{8'h5a};
    push_expected(1'b1);
    drive_bytes(1'b1);
    wait_drain("midrst");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    ready_low_cnt = 0;
    sel = 1'b1;
    in_byte_d = 8'h00;
    in_valid_d = 1'b0;
    in_last_d = 1'b0;
    blk_ready_d = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 1'b0;
    test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_fips();
    test_partial(1'b1);
    test_partial(1'b0);
    test_full_nopad();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
